// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle WIDTH-bit adder built around one 2-bit
// carry-lookahead slice. Operands are latched on accept, one 2-bit slice
// is summed per clock with a registered ripple carry linking slices, and
// the assembled sum is held until the consumer takes it.
//
// Optional feature macro: CLA_SEQ_OVF_EN adds the signed-overflow port ovf.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request
//   in_ready   block can accept operands this cycle (combinational)
//   a, b       WIDTH-bit operands, sampled on accept
//   cin        carry-in, sampled on accept
//   out_valid  result available
//   out_ready  consumer takes result
//   s          registered sum
//   cout       registered carry-out
//   ovf        registered signed overflow (CLA_SEQ_OVF_EN only)
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [IW:0]      w_base;
  logic [1:0]       w_a2;
  logic [1:0]       w_b2;
  logic [1:0]       w_g;
  logic [1:0]       w_p;
  logic             w_c1;
  logic             w_gm;
  logic             w_pm;
  logic             w_c2;
  logic [1:0]       w_sum;

  // ---------------- 2-bit CLA slice ----------------
  assign w_base = {r_idx, 1'b0};
  assign w_a2   = r_a[w_base +: 2];
  assign w_b2   = r_b[w_base +: 2];
  assign w_g    = w_a2 & w_b2;
  assign w_p    = w_a2 ^ w_b2;
  assign w_c1   = w_g[0] | (w_p[0] & r_carry);
  assign w_gm   = w_g[1] | (w_p[1] & w_g[0]);
  assign w_pm   = w_p[1] & w_p[0];
  assign w_c2   = w_gm | (w_pm & r_carry);
  assign w_sum  = {w_p[1] ^ w_c1, w_p[0] ^ r_carry};
  assign w_last = (r_idx == LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      RUN:  if (w_last) w_next = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_accept = in_valid & in_ready;
    if (w_accept) w_next = RUN;
  end

  // ---------------- Datapath ----------------
  // Operand registers carry no reset; they are only read during RUN.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_carry <= cin;
      r_idx   <= '0;
      r_s     <= '0;
    end else if (r_state == RUN) begin
      r_s[w_base +: 2] <= w_sum;
      r_carry          <= w_c2;
      if (w_last) r_cout <= w_c2;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;

  // On the final slice w_c1 is the carry into the MSB, w_c2 the carry out.
  always_ff @(posedge clk) begin
    if (rst || w_accept)               r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_c1 ^ w_c2;
  end

  assign ovf = r_ovf;
`endif

  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] s;
  logic        cout;

  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [1:0]  n_a = '0;
  logic [1:0]  n_b = '0;
  logic        n_cin = 1'b0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b0;
  logic [1:0]  n_s;
  logic        n_cout;

`ifdef CLA_SEQ_OVF_EN
  logic ovf;
  logic n_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout)
`ifdef CLA_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  cla_seq_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .cin(n_cin), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .s(n_s), .cout(n_cout)
`ifdef CLA_SEQ_OVF_EN
    , .ovf(n_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge.
  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic c);
    a = av; b = bv; cin = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_s",         {16'd0, s},         32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);

    // 0x00FF + 0x0001: exact latency of 8 edges
    accept(16'h00FF, 16'h0001, 1'b0);
    chk("t1_in_ready_run", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("t1_latency_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    step();
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_s",    {16'd0, s},    32'h0100);
    chk("t1_cout", {31'd0, cout}, 32'd0);
    consume();
    chk("t1_idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_idle_in_ready",  {31'd0, in_ready},  32'd1);

    // 0xFFFF + 0 + 1: carry through every slice
    accept(16'hFFFF, 16'h0000, 1'b1);
    wait_done("t2_done");
    chk("t2_s",    {16'd0, s},    32'h0000);
    chk("t2_cout", {31'd0, cout}, 32'd1);
    consume();

    // Backpressure with new operands waiting, then same-edge accept
    accept(16'h1234, 16'h1111, 1'b0);
    wait_done("t3_done");
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_in_ready_bp", {31'd0, in_ready}, 32'd0);
      step();
      chk("t3_s_hold",    {16'd0, s},          32'h2345);
      chk("t3_cout_hold", {31'd0, cout},       32'd0);
      chk("t3_valid_hold",{31'd0, out_valid},  32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_done", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_reaccept_run", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("t3_latency_%0d", i), {31'd0, out_valid}, 32'd0);
    end
    step();
    chk("t3b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3b_s",    {16'd0, s},    32'h0000);
    chk("t3b_cout", {31'd0, cout}, 32'd1);
    consume();

    // in_valid during RUN is ignored
    accept(16'h0100, 16'h0200, 1'b0);
    step(); step();
    a = 16'h1234; b = 16'h1234; cin = 1'b1; in_valid = 1'b1;
    #1;
    chk("t4_in_ready_busy", {31'd0, in_ready}, 32'd0);
    step();
    in_valid = 1'b0;
    wait_done("t4_done");
    chk("t4_s",    {16'd0, s},    32'h0300);
    chk("t4_cout", {31'd0, cout}, 32'd0);
    consume();

    // Reset in the middle of an operation (idx = 3)
    accept(16'h0F0F, 16'h0101, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_s",         {16'd0, s},         32'd0);
    chk("t5_cout",      {31'd0, cout},      32'd0);
    chk("t5_in_ready",  {31'd0, in_ready},  32'd1);
    accept(16'h0003, 16'h0005, 1'b0);
    wait_done("t5_done");
    chk("t5_after_s", {16'd0, s}, 32'h0008);
    consume();

`ifdef CLA_SEQ_OVF_EN
    accept(16'h7FFF, 16'h0001, 1'b0);
    wait_done("t6_done");
    chk("t6_ovf", {31'd0, ovf}, 32'd1);
    chk("t6_s",   {16'd0, s},   32'h8000);
    consume();
    accept(16'hFFFF, 16'h0001, 1'b0);
    wait_done("t7_done");
    chk("t7_ovf",  {31'd0, ovf},  32'd0);
    chk("t7_cout", {31'd0, cout}, 32'd1);
    consume();
`endif

    // WIDTH = 2: 0b11 + 0b01 + 1, one-cycle latency
    n_a = 2'b11; n_b = 2'b01; n_cin = 1'b1; n_in_valid = 1'b1;
    step();
    n_in_valid = 1'b0;
    chk("w2_run", {31'd0, n_out_valid}, 32'd0);
    step();
    chk("w2_out_valid", {31'd0, n_out_valid}, 32'd1);
    chk("w2_s",    {30'd0, n_s},    32'd1);
    chk("w2_cout", {31'd0, n_cout}, 32'd1);
`ifdef CLA_SEQ_OVF_EN
    chk("w2_ovf", {31'd0, n_ovf}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
